// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and constants for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

   localparam int unsigned RegAddrBusW = 5;
   localparam int unsigned RegBusW     = 32;

   localparam logic [RegBusW-1:0]     ZeroWord = '0;
   localparam logic [RegAddrBusW-1:0] RegZero  = '0;
   localparam logic                   Enable   = 1'b1;
   localparam logic                   Disable  = 1'b0;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO buffering long-latency results as {addr, data} entries.
// WB_PEND_QUERY_EN exposes the storage, read pointer and count for pending-result lookups.
module wb_result_fifo
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = RegAddrBusW + RegBusW,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [PW:0]      count_next
`ifdef WB_PEND_QUERY_EN
   ,
   output logic [PW:0]      count,
   output logic [PW-1:0]    rd_pos,
   output logic [DEPTH*W-1:0] entries
`endif
);

   localparam logic [PW:0] CntOne  = (PW+1)'(1);
   localparam logic [PW:0] CntFull = (PW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;

   always_comb begin
      count_next = cnt;
      unique case ({push, pop})
         2'b10:   count_next = cnt + CntOne;
         2'b01:   count_next = cnt - CntOne;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt <= count_next;
      end
   end

   // Storage needs no reset: entries are only visible through cnt.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == CntFull);
   assign empty = (cnt == '0);

`ifdef WB_PEND_QUERY_EN
   assign count  = cnt;
   assign rd_pos = rd_ptr;
   always_comb begin
      entries = '0;
      for (int i = 0; i < int'(DEPTH); i++) entries[i*W +: W] = mem[i];
   end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Regfile write-port arbiter: pipeline writes win, long-latency results queue and drain in idle slots.
// Define WB_PEND_QUERY_EN to add two combinational pending-result query ports.
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = RegAddrBusW,
   parameter int unsigned DW    = RegBusW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_waddr,
   input  logic [DW-1:0] pipe_wdata,
   input  logic          lu_valid,
   input  logic [AW-1:0] lu_waddr,
   input  logic [DW-1:0] lu_wdata,
   output logic          lu_ready,
   output logic          stall_req,
`ifdef WB_PEND_QUERY_EN
   input  logic [AW-1:0] q1_addr,
   input  logic [AW-1:0] q2_addr,
   output logic          q1_hit,
   output logic          q2_hit,
   output logic [DW-1:0] q1_data,
   output logic [DW-1:0] q2_data,
`endif
   output logic [AW-1:0] rw,
   output logic [DW-1:0] wdata,
   output logic          we
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned W  = AW + DW;

   logic          pipe_ok, lu_ok, push, pop, bypass, full, empty;
   logic [W-1:0]  head;
   logic [PW:0]   count_next;
   logic          we_d, we_q, stall_q;
   logic [AW-1:0] rw_d, rw_q;
   logic [DW-1:0] wdata_d, wdata_q;

`ifdef WB_PEND_QUERY_EN
   logic [PW:0]       count;
   logic [PW-1:0]     rd_pos;
   logic [DEPTH*W-1:0] entries;
`endif

   wb_result_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .din        ({lu_waddr, lu_wdata}),
      .dout       (head),
      .full       (full),
      .empty      (empty),
`ifdef WB_PEND_QUERY_EN
      .count      (count),
      .rd_pos     (rd_pos),
      .entries    (entries),
`endif
      .count_next (count_next)
   );

   assign lu_ready = ~full;

   // Register-0 writes never claim a slot; an lu result to r0 still handshakes but is dropped.
   always_comb begin
      pipe_ok = pipe_we && (pipe_waddr != '0);
      lu_ok   = lu_valid && (lu_waddr != '0);
      pop     = !pipe_ok && !empty;
      bypass  = !pipe_ok && empty && lu_ok;
      push    = lu_ok && !full && !bypass;

      we_d    = Disable;
      rw_d    = rw_q;
      wdata_d = wdata_q;
      if (pipe_ok) begin
         we_d    = Enable;
         rw_d    = pipe_waddr;
         wdata_d = pipe_wdata;
      end else if (pop) begin
         we_d    = Enable;
         rw_d    = head[W-1:DW];
         wdata_d = head[DW-1:0];
      end else if (bypass) begin
         we_d    = Enable;
         rw_d    = lu_waddr;
         wdata_d = lu_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= Disable;
         rw_q    <= '0;
         wdata_q <= '0;
         stall_q <= Disable;
      end else begin
         we_q    <= we_d;
         rw_q    <= rw_d;
         wdata_q <= wdata_d;
         stall_q <= (count_next == (PW+1)'(DEPTH));
      end
   end

   assign we        = we_q;
   assign rw        = rw_q;
   assign wdata     = wdata_q;
   assign stall_req = stall_q;

`ifdef WB_PEND_QUERY_EN
   // Scan oldest to youngest so the youngest match overrides; output register is oldest of all.
   function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
      logic [DW:0]   res;
      logic [PW-1:0] idx;
      res = '0;
      if (a != '0) begin
         if (we_q && (rw_q == a)) res = {1'b1, wdata_q};
         for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_pos + PW'(k);
            if (((PW+1)'(k) < count) && (entries[int'(idx)*W + DW +: AW] == a))
               res = {1'b1, entries[int'(idx)*W +: DW]};
         end
      end
      return res;
   endfunction

   assign {q1_hit, q1_data} = lookup(q1_addr);
   assign {q2_hit, q2_data} = lookup(q2_addr);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (DEPTH=4); query checks need WB_PEND_QUERY_EN.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        lu_ready;
   logic        stall_req;
   logic [4:0]  rw;
   logic [31:0] wdata;
   logic        we;
`ifdef WB_PEND_QUERY_EN
   logic [4:0]  q1_addr, q2_addr;
   logic        q1_hit, q2_hit;
   logic [31:0] q1_data, q2_data;
`endif

   int vectors = 0;
   int miscompares = 0;

   regfile_wb_arbiter #(
      .DEPTH (4),
      .AW    (5),
      .DW    (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .lu_valid   (lu_valid),
      .lu_waddr   (lu_waddr),
      .lu_wdata   (lu_wdata),
      .lu_ready   (lu_ready),
      .stall_req  (stall_req),
`ifdef WB_PEND_QUERY_EN
      .q1_addr    (q1_addr),
      .q2_addr    (q2_addr),
      .q1_hit     (q1_hit),
      .q2_hit     (q2_hit),
      .q1_data    (q1_data),
      .q2_data    (q2_data),
`endif
      .rw         (rw),
      .wdata      (wdata),
      .we         (we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
      check({tag, "_we"}, 32'(we), 32'd1);
      check({tag, "_rw"}, 32'(rw), 32'(a));
      check({tag, "_wdata"}, wdata, d);
   endtask

   logic [36:0] expq[$];
   logic [36:0] front;
   int          k, cyc;
   logic        acc, pf;
   logic [31:0] pd;

   initial begin
      rst = 1'b0;
      pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
`ifdef WB_PEND_QUERY_EN
      q1_addr = '0; q2_addr = '0;
`endif
      #3;
      check("rst_we", 32'(we), 32'd0);
      check("rst_rw", 32'(rw), 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_stall", 32'(stall_req), 32'd0);
      check("rst_lu_ready", 32'(lu_ready), 32'd1);
      rst = 1'b1;

      // Bypass straight to the write port when the FIFO is empty
      lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
      tick();
      lu_valid = 1'b0;
      check_wr("bypass", 5'd5, 32'hDEADBEEF);
      check("bypass_stall", 32'(stall_req), 32'd0);
      tick();
      check("bypass_idle_we", 32'(we), 32'd0);
      check("bypass_hold_rw", 32'(rw), 32'd5);
      check("bypass_hold_wdata", wdata, 32'hDEADBEEF);

      // Pipe priority while lu results fill the FIFO
      for (int i = 1; i <= 6; i++) begin
         pipe_we = 1'b1; pipe_waddr = 5'(i); pipe_wdata = 32'h100 + 32'(i);
         lu_valid = (i <= 4); lu_waddr = 5'(9 + i); lu_wdata = 32'hC000_0000 + 32'(9 + i);
         check("prio_lu_ready", 32'(lu_ready), 32'(i <= 4));
         tick();
         check_wr("prio_pipe", 5'(i), 32'h100 + 32'(i));
         check("prio_stall", 32'(stall_req), 32'(i >= 4));
      end
      pipe_we = 1'b0; lu_valid = 1'b0;
      for (int a = 10; a <= 13; a++) begin
         tick();
         check_wr("drain", 5'(a), 32'hC000_0000 + 32'(a));
         check("drain_stall", 32'(stall_req), 32'd0);
      end
      tick();
      check("drain_done_we", 32'(we), 32'd0);

      // Register 0 writes are dropped; lu bypass takes the slot
      pipe_we = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hBAD;
      lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h77;
      tick();
      check_wr("r0_bypass", 5'd7, 32'h77);
      lu_valid = 1'b0;
      tick();
      check("r0_pipe_we", 32'(we), 32'd0);
      check("r0_pipe_rw", 32'(rw), 32'd7);
      pipe_we = 1'b0;
      lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hBAD;
      check("r0_lu_ready", 32'(lu_ready), 32'd1);
      tick();
      lu_valid = 1'b0;
      check("r0_lu_we", 32'(we), 32'd0);
      tick();
      check("r0_lu_no_enq", 32'(we), 32'd0);

      // Reset in the middle of a drain discards the buffered entries
      pipe_we = 1'b1; pipe_waddr = 5'd2; pipe_wdata = 32'h22;
      lu_valid = 1'b1;
      for (int a = 20; a <= 22; a++) begin
         lu_waddr = 5'(a); lu_wdata = 32'hA000 + 32'(a);
         tick();
      end
      pipe_we = 1'b0; lu_valid = 1'b0;
      tick();
      check_wr("mid_drain", 5'd20, 32'hA014);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_we", 32'(we), 32'd0);
      check("mid_rst_rw", 32'(rw), 32'd0);
      check("mid_rst_wdata", wdata, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 3; n++) begin
         check("post_rst_lu_ready", 32'(lu_ready), 32'd1);
         tick();
         check("post_rst_no_stale", 32'(we), 32'd0);
      end

      // Wrap and concurrency: 20 lu results against alternating pipe writes
      k = 0; cyc = 0;
      while ((k < 20 || expq.size() != 0) && cyc < 300) begin
         pipe_we = (cyc % 2 == 0) && !stall_req && (k < 20);
         pipe_waddr = 5'd3; pipe_wdata = 32'h3000 + 32'(cyc);
         lu_valid = (k < 20);
         lu_waddr = 5'(16 + k % 15); lu_wdata = 32'h5000 + 32'(k);
         acc = lu_valid && lu_ready; pf = pipe_we; pd = pipe_wdata;
         tick();
         if (acc) begin
            expq.push_back({lu_waddr, lu_wdata});
            k++;
         end
         if (pf) begin
            check_wr("wrap_pipe", 5'd3, pd);
         end else begin
            check("wrap_we", 32'(we), 32'(expq.size() != 0));
            if (we && expq.size() != 0) begin
               front = expq.pop_front();
               check("wrap_rw", 32'(rw), 32'(front[36:32]));
               check("wrap_wdata", wdata, front[31:0]);
            end
         end
         cyc++;
      end
      pipe_we = 1'b0; lu_valid = 1'b0;
      check("wrap_pushes", 32'(k), 32'd20);
      check("wrap_left", 32'(expq.size()), 32'd0);
      tick();
      check("wrap_idle", 32'(we), 32'd0);

`ifdef WB_PEND_QUERY_EN
      // Query returns the youngest pending value for a register
      pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
      lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h11;
      tick();
      lu_wdata = 32'h22;
      tick();
      lu_valid = 1'b0;
      q1_addr = 5'd9; q2_addr = 5'd0;
      #1;
      check("q1_hit", 32'(q1_hit), 32'd1);
      check("q1_data", q1_data, 32'h22);
      check("q2_zero_hit", 32'(q2_hit), 32'd0);
      q2_addr = 5'd4;
      #1;
      check("q2_outreg_hit", 32'(q2_hit), 32'd1);
      check("q2_outreg_data", q2_data, 32'h44);
      pipe_we = 1'b0;
      tick();
      check_wr("q_drain0", 5'd9, 32'h11);
      tick();
      check_wr("q_drain1", 5'd9, 32'h22);
      check("q1_outreg_data", q1_data, 32'h22);
      tick();
      check("q_after_hit", 32'(q1_hit), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
